// File: rtl/tiny_riscv0_mem_if.sv
// Bus bundle between the tiny_riscv0 core (master) and its memory subsystem (slave):
// instruction fetch, data load/store and the instruction-memory loader port.
interface tiny_riscv0_mem_if;
    logic        imem_rd;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        dmem_rd;
    logic [31:0] dmem_raddr;
    logic [31:0] dmem_rdata;
    logic        dmem_wr;
    logic [31:0] dmem_waddr;
    logic [31:0] dmem_wdata;
    logic        ld_we;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    modport master (
        output imem_rd, imem_addr, dmem_rd, dmem_raddr, dmem_wr, dmem_waddr, dmem_wdata,
               ld_we, ld_addr, ld_data,
        input  imem_rdata, dmem_rdata
    );

    modport slave (
        input  imem_rd, imem_addr, dmem_rd, dmem_raddr, dmem_wr, dmem_waddr, dmem_wdata,
               ld_we, ld_addr, ld_data,
        output imem_rdata, dmem_rdata
    );
endinterface

// File: rtl/tiny_riscv0_mem.sv
// Harvard memory responder for tiny_riscv0: word-addressed IMEM/DMEM with 1-cycle reads,
// write-first forwarding, an MMIO block (HALT/GPIO/CYCLE) and an IMEM loader port.
module tiny_riscv0_mem #(
    parameter int          IMEM_AW   = 10,
    parameter int          DMEM_AW   = 10,
    parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
    input  logic             clk,
    input  logic             rst,
    tiny_riscv0_mem_if.slave bus,
    output logic [31:0]      gpio_out,
    output logic             halted,
    output logic [31:0]      halt_code,
    output logic             err
);
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [25:0] OFF_HALT  = 26'd0;
    localparam logic [25:0] OFF_GPIO  = 26'd1;
    localparam logic [25:0] OFF_CYCLE = 26'd2;

    logic [31:0] imem_mem [2**IMEM_AW];
    logic [31:0] dmem_mem [2**DMEM_AW];

    logic [31:0] imem_rdata_q, imem_rdata_d;
    logic [31:0] dmem_rdata_q, dmem_rdata_d;
    logic [31:0] gpio_q, gpio_d;
    logic [31:0] halt_code_q, halt_code_d;
    logic [31:0] cycle_q, cycle_d;
    logic        halted_q, halted_d;
    logic        err_q, err_d;

    logic               imem_ok, ld_ok;
    logic               rd_mmio, rd_ram, wr_mmio, wr_ram;
    logic [IMEM_AW-1:0] imem_idx, ld_idx;
    logic [DMEM_AW-1:0] rd_idx, wr_idx;
    logic [25:0]        rd_off, wr_off;
    logic               wr_en, dmem_we, ld_wr, halt_we, gpio_we, bad_access;
    logic               unused_addr_bits;

    assign unused_addr_bits = ^{bus.imem_addr[1:0], bus.ld_addr[1:0],
                                bus.dmem_raddr[1:0], bus.dmem_waddr[1:0]};

    // Address decode; all writes are suppressed once halted.
    always_comb begin
        imem_ok  = (bus.imem_addr[31:IMEM_AW+2] == '0);
        ld_ok    = (bus.ld_addr[31:IMEM_AW+2] == '0);
        imem_idx = bus.imem_addr[IMEM_AW+1:2];
        ld_idx   = bus.ld_addr[IMEM_AW+1:2];

        rd_mmio  = (bus.dmem_raddr[31:28] == MMIO_BASE[31:28]);
        wr_mmio  = (bus.dmem_waddr[31:28] == MMIO_BASE[31:28]);
        rd_ram   = !rd_mmio && (bus.dmem_raddr[31:DMEM_AW+2] == '0);
        wr_ram   = !wr_mmio && (bus.dmem_waddr[31:DMEM_AW+2] == '0);
        rd_idx   = bus.dmem_raddr[DMEM_AW+1:2];
        wr_idx   = bus.dmem_waddr[DMEM_AW+1:2];
        rd_off   = bus.dmem_raddr[27:2] - MMIO_BASE[27:2];
        wr_off   = bus.dmem_waddr[27:2] - MMIO_BASE[27:2];

        wr_en    = bus.dmem_wr && !halted_q;
        dmem_we  = wr_en && wr_ram;
        halt_we  = wr_en && wr_mmio && (wr_off == OFF_HALT);
        gpio_we  = wr_en && wr_mmio && (wr_off == OFF_GPIO);
        ld_wr    = bus.ld_we && ld_ok;

        bad_access = (bus.imem_rd && !imem_ok)
                   | (bus.ld_we && !ld_ok)
                   | (bus.dmem_rd && (rd_mmio ? (rd_off > OFF_CYCLE) : !rd_ram))
                   | (bus.dmem_wr && (wr_mmio ? (wr_off > OFF_CYCLE) : !wr_ram));
    end

    // Next state; same-cycle writes are forwarded to reads of the same word.
    always_comb begin
        imem_rdata_d = imem_rdata_q;
        dmem_rdata_d = dmem_rdata_q;
        gpio_d       = gpio_we ? bus.dmem_wdata : gpio_q;
        halted_d     = halted_q | halt_we;
        halt_code_d  = halt_we ? bus.dmem_wdata : halt_code_q;
        cycle_d      = halted_q ? cycle_q : cycle_q + 32'd1;
        err_d        = err_q | bad_access;

        if (bus.imem_rd) begin
            if (!imem_ok)
                imem_rdata_d = NOP;
            else if (ld_wr && (ld_idx == imem_idx))
                imem_rdata_d = bus.ld_data;
            else
                imem_rdata_d = imem_mem[imem_idx];
        end

        if (bus.dmem_rd) begin
            if (rd_mmio) begin
                case (rd_off)
                    OFF_HALT:  dmem_rdata_d = halt_we ? bus.dmem_wdata : halt_code_q;
                    OFF_GPIO:  dmem_rdata_d = gpio_we ? bus.dmem_wdata : gpio_q;
                    OFF_CYCLE: dmem_rdata_d = cycle_q;
                    default:   dmem_rdata_d = 32'h0;
                endcase
            end else if (rd_ram) begin
                if (dmem_we && (wr_idx == rd_idx))
                    dmem_rdata_d = bus.dmem_wdata;
                else
                    dmem_rdata_d = dmem_mem[rd_idx];
            end else begin
                dmem_rdata_d = 32'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            imem_rdata_q <= NOP;
            dmem_rdata_q <= 32'h0;
            gpio_q       <= 32'h0;
            halted_q     <= 1'b0;
            halt_code_q  <= 32'h0;
            cycle_q      <= 32'h0;
            err_q        <= 1'b0;
        end else begin
            imem_rdata_q <= imem_rdata_d;
            dmem_rdata_q <= dmem_rdata_d;
            gpio_q       <= gpio_d;
            halted_q     <= halted_d;
            halt_code_q  <= halt_code_d;
            cycle_q      <= cycle_d;
            err_q        <= err_d;
        end
    end

    // Arrays are never cleared; reset only blocks writes in its own cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (dmem_we)
                dmem_mem[wr_idx] <= bus.dmem_wdata;
            if (ld_wr)
                imem_mem[ld_idx] <= bus.ld_data;
        end
    end

    assign bus.imem_rdata = imem_rdata_q;
    assign bus.dmem_rdata = dmem_rdata_q;
    assign gpio_out       = gpio_q;
    assign halted         = halted_q;
    assign halt_code      = halt_code_q;
    assign err            = err_q;
endmodule

// File: tb/tb_tiny_riscv0_mem.sv
// Self-checking bench for tiny_riscv0_mem: directed scenarios plus randomized traffic,
// all checked against a word-level behavioural model of the memory map.
module tb_tiny_riscv0_mem;
    localparam int          IMEM_AW = 10;
    localparam int          DMEM_AW = 10;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] gpio_out, halt_code;
    logic        halted, err;

    always #5 clk = ~clk;

    tiny_riscv0_mem_if bus();

    tiny_riscv0_mem #(
        .IMEM_AW  (IMEM_AW),
        .DMEM_AW  (DMEM_AW),
        .MMIO_BASE(32'h8000_0000)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus.slave),
        .gpio_out (gpio_out),
        .halted   (halted),
        .halt_code(halt_code),
        .err      (err)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] imem_m [2**IMEM_AW];
    bit          imem_v [2**IMEM_AW];
    logic [31:0] dmem_m [2**DMEM_AW];
    bit          dmem_v [2**DMEM_AW];
    logic [31:0] m_imem_rdata, m_dmem_rdata, m_gpio, m_halt_code, m_cycle;
    bit          m_imem_k, m_dmem_k, m_halted, m_err;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // 0 = RAM, 1 = MMIO, 2 = out of range
    function automatic int region(input logic [31:0] a, input int aw, input bit allow_mmio);
        if (allow_mmio && a[31:28] == 4'h8) return 1;
        if ((a >> (aw + 2)) == 32'h0) return 0;
        return 2;
    endfunction

    task automatic modelStep(input bit r, input bit i_rd, input logic [31:0] i_a,
                             input bit d_rd, input logic [31:0] d_ra,
                             input bit d_wr, input logic [31:0] d_wa, input logic [31:0] d_wd,
                             input bit l_we, input logic [31:0] l_a, input logic [31:0] l_d);
        logic [31:0] old_cycle;
        bit          old_halted;
        int          idx;
        logic [27:0] off;
        if (r) begin
            m_imem_rdata = NOP; m_imem_k = 1; m_dmem_rdata = 0; m_dmem_k = 1;
            m_gpio = 0; m_halted = 0; m_halt_code = 0; m_err = 0; m_cycle = 0;
            return;
        end
        old_cycle  = m_cycle;
        old_halted = m_halted;
        // Writes happen first so that same-cycle reads observe them.
        if (l_we) begin
            if (region(l_a, IMEM_AW, 0) == 0) begin
                idx = int'(l_a[IMEM_AW+1:2]);
                imem_m[idx] = l_d; imem_v[idx] = 1;
            end else m_err = 1;
        end
        if (d_wr) begin
            case (region(d_wa, DMEM_AW, 1))
                0: if (!old_halted) begin
                       idx = int'(d_wa[DMEM_AW+1:2]);
                       dmem_m[idx] = d_wd; dmem_v[idx] = 1;
                   end
                1: begin
                       off = d_wa[27:0] & ~28'h3;
                       if (off == 28'h0) begin
                           if (!old_halted) begin m_halted = 1; m_halt_code = d_wd; end
                       end else if (off == 28'h4) begin
                           if (!old_halted) m_gpio = d_wd;
                       end else if (off != 28'h8) m_err = 1;
                   end
                default: m_err = 1;
            endcase
        end
        if (i_rd) begin
            if (region(i_a, IMEM_AW, 0) == 0) begin
                idx = int'(i_a[IMEM_AW+1:2]);
                m_imem_rdata = imem_m[idx]; m_imem_k = imem_v[idx];
            end else begin
                m_imem_rdata = NOP; m_imem_k = 1; m_err = 1;
            end
        end
        if (d_rd) begin
            m_dmem_k = 1;
            case (region(d_ra, DMEM_AW, 1))
                0: begin
                       idx = int'(d_ra[DMEM_AW+1:2]);
                       m_dmem_rdata = dmem_m[idx]; m_dmem_k = dmem_v[idx];
                   end
                1: begin
                       off = d_ra[27:0] & ~28'h3;
                       if (off == 28'h0) m_dmem_rdata = m_halt_code;
                       else if (off == 28'h4) m_dmem_rdata = m_gpio;
                       else if (off == 28'h8) m_dmem_rdata = old_cycle;
                       else begin m_dmem_rdata = 0; m_err = 1; end
                   end
                default: begin m_dmem_rdata = 0; m_err = 1; end
            endcase
        end
        if (!old_halted) m_cycle = old_cycle + 1;
    endtask

    task automatic applyStimulus(input bit r, input bit i_rd, input logic [31:0] i_a,
                                 input bit d_rd, input logic [31:0] d_ra,
                                 input bit d_wr, input logic [31:0] d_wa, input logic [31:0] d_wd,
                                 input bit l_we, input logic [31:0] l_a, input logic [31:0] l_d);
        rst = r;
        bus.imem_rd = i_rd; bus.imem_addr = i_a;
        bus.dmem_rd = d_rd; bus.dmem_raddr = d_ra;
        bus.dmem_wr = d_wr; bus.dmem_waddr = d_wa; bus.dmem_wdata = d_wd;
        bus.ld_we = l_we; bus.ld_addr = l_a; bus.ld_data = l_d;
        @(posedge clk);
        modelStep(r, i_rd, i_a, d_rd, d_ra, d_wr, d_wa, d_wd, l_we, l_a, l_d);
        #1;
        if (m_imem_k) checkOutput("imem_rdata", bus.imem_rdata, m_imem_rdata);
        if (m_dmem_k) checkOutput("dmem_rdata", bus.dmem_rdata, m_dmem_rdata);
        checkOutput("gpio_out", gpio_out, m_gpio);
        checkOutput("halted", {31'h0, halted}, {31'h0, m_halted});
        checkOutput("halt_code", halt_code, m_halt_code);
        checkOutput("err", {31'h0, err}, {31'h0, m_err});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic doReset();
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic iRead(input logic [31:0] a);
        applyStimulus(0, 1, a, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic ldWrite(input logic [31:0] a, input logic [31:0] d);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, a, d);
    endtask
    task automatic dRead(input logic [31:0] a);
        applyStimulus(0, 0, 0, 1, a, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic dWrite(input logic [31:0] a, input logic [31:0] d);
        applyStimulus(0, 0, 0, 0, 0, 1, a, d, 0, 0, 0);
    endtask

    function automatic logic [31:0] randWindow(input int lo, input int hi);
        logic [31:0] a;
        a = (32'($urandom_range(hi, lo)) << 2) | 32'($urandom_range(3, 0));
        return a;
    endfunction

    function automatic logic [31:0] randDmemAddr(input bit for_write);
        case ($urandom_range(9, 0))
            0:       return 32'h8000_0004;
            1:       return 32'h8000_0008;
            2:       return for_write ? 32'h8000_0004 : 32'h8000_0000;
            default: return randWindow(16, 31);
        endcase
    endfunction

    logic [31:0] c0, c1;

    initial begin
        for (int i = 0; i < 2**IMEM_AW; i++) imem_v[i] = 0;
        for (int i = 0; i < 2**DMEM_AW; i++) dmem_v[i] = 0;
        doReset();
        doReset();
        checkOutput("reset_nop", bus.imem_rdata, 32'h0000_0013);

        // Loader then back-to-back fetches
        ldWrite(32'h0, 32'h0050_0093);
        ldWrite(32'h4, 32'h0010_8113);
        iRead(32'h0);
        checkOutput("fetch0", bus.imem_rdata, 32'h0050_0093);
        iRead(32'h4);
        checkOutput("fetch1", bus.imem_rdata, 32'h0010_8113);

        // Store and load of the same word in one cycle
        applyStimulus(0, 0, 0, 1, 32'h40, 1, 32'h40, 32'hDEAD_BEEF, 0, 0, 0);
        checkOutput("raw_fwd", bus.dmem_rdata, 32'hDEAD_BEEF);
        dRead(32'h44);
        dRead(32'h40);
        checkOutput("raw_keep", bus.dmem_rdata, 32'hDEAD_BEEF);

        // GPIO and CYCLE
        dWrite(32'h8000_0004, 32'h0000_00A5);
        checkOutput("gpio_wr", gpio_out, 32'h0000_00A5);
        dRead(32'h8000_0004);
        checkOutput("gpio_rd", bus.dmem_rdata, 32'h0000_00A5);
        dRead(32'h8000_0008);
        c0 = bus.dmem_rdata;
        idle(9);
        dRead(32'h8000_0008);
        c1 = bus.dmem_rdata;
        checkOutput("cycle_delta", c1 - c0, 32'd10);

        // Preload windows, then randomized traffic (no halt, no out-of-range)
        for (int i = 0; i < 16; i++) ldWrite(32'(i) << 2, $urandom);
        for (int i = 16; i < 32; i++) dWrite(32'(i) << 2, $urandom);
        for (int n = 0; n < 400; n++) begin
            applyStimulus(0,
                          1'($urandom_range(1, 0)), randWindow(0, 15),
                          1'($urandom_range(1, 0)), randDmemAddr(0),
                          1'($urandom_range(1, 0)), randDmemAddr(1), $urandom,
                          ($urandom_range(3, 0) == 0), randWindow(0, 15), $urandom);
        end

        // Halt: later stores dropped, CYCLE frozen
        dWrite(32'h10, 32'h77);
        dWrite(32'h8000_0000, 32'h1);
        checkOutput("halted_set", {31'h0, halted}, 32'h1);
        checkOutput("halt_code_set", halt_code, 32'h1);
        dWrite(32'h10, 32'h55);
        dRead(32'h10);
        checkOutput("halt_drop", bus.dmem_rdata, 32'h77);
        for (int i = 0; i < 5; i++) dRead(32'h8000_0008);
        dWrite(32'h8000_0004, 32'hFF);
        dRead(32'h8000_0000);
        checkOutput("halt_rd", bus.dmem_rdata, 32'h1);

        // Out-of-range and bad-offset accesses raise sticky err
        doReset();
        dRead(32'h0010_0000);
        checkOutput("oor_rdata", bus.dmem_rdata, 32'h0);
        checkOutput("oor_err", {31'h0, err}, 32'h1);
        dWrite(32'h24, 32'h1234_5678);
        dRead(32'h24);
        iRead(32'h0);
        checkOutput("err_sticky", {31'h0, err}, 32'h1);
        doReset();
        dWrite(32'h8000_0008, 32'h5);
        checkOutput("cycle_wr_noerr", {31'h0, err}, 32'h0);
        iRead(32'h0000_1000);
        checkOutput("imem_oor_nop", bus.imem_rdata, NOP);
        checkOutput("imem_oor_err", {31'h0, err}, 32'h1);
        doReset();
        ldWrite(32'h0000_1000, 32'h1);
        checkOutput("ld_oor_err", {31'h0, err}, 32'h1);
        doReset();
        dWrite(32'h8000_000C, 32'h1);
        checkOutput("mmio_bad_err", {31'h0, err}, 32'h1);

        // Reset during a store drops it and preserves earlier contents
        doReset();
        dWrite(32'h20, 32'hAAAA_0000);
        dWrite(32'h8000_0004, 32'h3C);
        applyStimulus(1, 0, 0, 0, 0, 1, 32'h20, 32'hBBBB_1111, 0, 0, 0);
        checkOutput("rst_gpio", gpio_out, 32'h0);
        dRead(32'h20);
        checkOutput("rst_drop", bus.dmem_rdata, 32'hAAAA_0000);
        dRead(32'h24);
        checkOutput("rst_keep", bus.dmem_rdata, 32'h1234_5678);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/tiny_riscv0_mem.md
Name: tiny_riscv0_mem

Overview:
Harvard memory responder serving the tiny_riscv0 core's instruction and data RAM interfaces, at the other end of the core's imem_*/dmem_* ports. Provides synchronous 1-cycle-latency instruction and data reads and single-cycle data writes. Includes a small MMIO block (halt/exit register, GPIO output register, cycle counter) and a loader port that lets the bench program instruction memory while the core is held in reset. Used as the memory subsystem in simulation and FPGA top levels.

Parameters:
IMEM_AW, 10, instruction memory word-address width (depth 2**IMEM_AW words)
DMEM_AW, 10, data memory word-address width (depth 2**DMEM_AW words)
MMIO_BASE, 32'h8000_0000, base of MMIO region (decoded on addr[31:28])

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_rd  in  1  instruction read request
imem_addr  in  32  instruction byte address
imem_rdata  out  32  instruction word, valid cycle after request
dmem_rd  in  1  data read request
dmem_raddr  in  32  data read byte address
dmem_rdata  out  32  read data, valid cycle after request
dmem_wr  in  1  data write strobe
dmem_waddr  in  32  data write byte address
dmem_wdata  in  32  data write word
ld_we  in  1  loader write enable (instruction memory)
ld_addr  in  32  loader byte address
ld_data  in  32  loader word
gpio_out  out  32  GPIO output register
halted  out  1  sticky halt flag
halt_code  out  32  value written to HALT register
err  out  1  sticky out-of-range access flag

Behaviour:
- Reset (sync, rst=1 at clk edge): imem_rdata=32'h0000_0013 (NOP), dmem_rdata=0, gpio_out=0, halted=0, halt_code=0, err=0, cycle counter=0. Memory arrays not cleared.
- Addressing: word-only. addr[1:0] ignored. IMEM index=addr[IMEM_AW+1:2], DMEM index=addr[DMEM_AW+1:2].
- Region decode: addr[31:28]==MMIO_BASE[31:28] selects MMIO. Otherwise in range iff addr[31:IMEM_AW+2]==0 (imem) or addr[31:DMEM_AW+2]==0 (dmem). Anything else is out of range.
- Instruction read: imem_rd=1 at edge t registers IMEM[index] into imem_rdata, visible at t+1. imem_rd=0 holds imem_rdata. Out-of-range read returns NOP and sets err.
- Data read: dmem_rd=1 at edge t updates dmem_rdata at t+1. dmem_rd=0 holds. Out-of-range read returns 0 and sets err.
- Data write: dmem_wr=1 writes DMEM[index] at the edge. Out-of-range write is dropped and sets err.
- Read-during-write, same word, same cycle: write-first. dmem_rdata returns dmem_wdata. Required because the core issues a load's read in the same cycle the preceding store writes.
- Loader: ld_we=1 writes IMEM at the edge, allowed at any time. Simultaneous imem read of the same index returns ld_data (write-first). Out-of-range ld_addr is dropped and sets err.
- MMIO (offsets from MMIO_BASE, word aligned):
  - 0x0 HALT: write sets halted=1 and halt_code=wdata. Reads return halt_code.
  - 0x4 GPIO: read/write, gpio_out.
  - 0x8 CYCLE: read-only, 32-bit free-running, +1 per clk, wraps 0xFFFF_FFFF→0. Writes are ignored and do not set err.
  - Other MMIO offsets: reads return 0, writes dropped, err set.
  - MMIO reads have 1-cycle latency. A read of CYCLE returns the counter value at the request edge.
  - Write+read of the same MMIO register in one cycle: write-first.
- Halt: once halted=1, all subsequent dmem writes (RAM and MMIO) are dropped and the CYCLE counter freezes. Reads still serviced. Cleared only by rst.
- err: sticky until rst.
- Reset mid-operation: rst takes priority over all writes in that cycle. Array contents written before rst are preserved.

Test Plan:
- Loader writes 0x00500093 to byte addr 0x0 and 0x00108113 to 0x4. Then imem_rd with addr 0x0 at t, 0x4 at t+1 -> imem_rdata=0x00500093 at t+1 and 0x00108113 at t+2. Right after reset, imem_rdata=0x13.
- dmem_wr addr 0x40 data 0xDEADBEEF together with dmem_rd raddr 0x40 in the same cycle -> dmem_rdata=0xDEADBEEF next cycle (write-first). Read of 0x44 unwritten does not alter the 0x40 data.
- Write 0x000000A5 to 0x8000_0004 -> gpio_out=0xA5 next cycle. Read of 0x8000_0004 -> 0xA5. Read 0x8000_0008 at cycle N, then again 10 cycles later -> difference of 10.
- Write 0x1 to 0x8000_0000 -> halted=1, halt_code=1. Then write 0x55 to dmem 0x10 -> a read of 0x10 returns the old value. CYCLE stays constant across 5 reads.
- dmem read of 0x0010_0000 with DMEM_AW=10 -> dmem_rdata=0, err=1. err remains 1 through later valid accesses until rst.
- Assert rst while a dmem_wr to 0x20 is active -> write dropped, all outputs at reset values. Earlier contents of 0x24 are still readable after rst.
